// File: rtl/tetris_pkg.sv
// Shared board geometry and lock-engine state encoding for the tetris datapath.
package tetris_pkg;
    localparam int BOARD_W     = 10;
    localparam int BOARD_H     = 24;
    localparam int HIDDEN_ROWS = 4;
    localparam int COLOUR_W    = 6;
    localparam int ADDR_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN,
        SHIFT_RD,
        SHIFT_WR,
        CLEAR_TOP,
        DONE
    } lock_state_t;
endpackage

// File: rtl/board_addr.sv
// Row-major board address: y*BOARD_W + x, kept in ADDR_W bits.
module board_addr
    import tetris_pkg::*;
(
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    output logic [ADDR_W-1:0] addr
);
    assign addr = y * ADDR_W'(BOARD_W) + x;
endmodule

// File: rtl/lut.sv
// Tetromino cell offsets and colour; cell k sits in bits [2k+1:2k].
// The I piece is vertical on odd rotations; other pieces use their spawn orientation.
module lut (
    input  logic [2:0] block,
    input  logic [1:0] rotation,
    output logic [7:0] coord_x,
    output logic [7:0] coord_y,
    output logic [5:0] colour
);
    always_comb begin
        coord_x = 8'd0;
        coord_y = 8'd0;
        colour  = {3'b000, block} + 6'd1;
        case (block)
            3'd0: begin
                if (rotation[0]) begin
                    coord_y = 8'b11_10_01_00;
                end else begin
                    coord_x = 8'b11_10_01_00;
                end
            end
            3'd1: begin coord_x = 8'b01_00_01_00; coord_y = 8'b01_01_00_00; end
            3'd2: begin coord_x = 8'b01_10_01_00; coord_y = 8'b01_00_00_00; end
            3'd3: begin coord_x = 8'b01_00_10_01; coord_y = 8'b01_01_00_00; end
            3'd4: begin coord_x = 8'b10_01_01_00; coord_y = 8'b01_01_00_00; end
            3'd5: begin coord_x = 8'b10_01_00_00; coord_y = 8'b01_01_01_00; end
            3'd6: begin coord_x = 8'b10_01_00_10; coord_y = 8'b01_01_01_00; end
            default: colour = 6'd0;
        endcase
    end
endmodule

// File: rtl/piece_lock.sv
// Writes a landed piece into board RAM, then clears full rows by shifting the rows above down.
//
// state     | meaning
// IDLE      | waiting for start
// WRITE     | writing piece cell k (4 cycles)
// SCAN      | reading row r, AND-reducing occupancy (BOARD_W+1 cycles)
// SHIFT_RD  | reading cell (s-1,c)
// SHIFT_WR  | writing that value to (s,c)
// CLEAR_TOP | zeroing row 0
// DONE      | complete pulse; start accepted here too
module piece_lock
    import tetris_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [4:0]          X_anchor,
    input  logic [5:0]          Y_anchor,
    input  logic [2:0]          block,
    input  logic [1:0]          rotation,
    input  logic [COLOUR_W-1:0] ram_Q,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [COLOUR_W-1:0] ram_data,
    output logic                ram_wren,
    output logic                busy,
    output logic                complete,
    output logic [2:0]          lines_cleared,
    output logic                top_out
);
    localparam logic [3:0] LAST_COL = 4'(BOARD_W - 1);
    localparam logic [3:0] ACC_COL  = 4'(BOARD_W);
    localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

    lock_state_t state_q, state_d;
    logic [4:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [2:0]  blk_q, blk_d;
    logic [1:0]  rot_q, rot_d;
    logic [1:0]  k_q, k_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  shf_q, shf_d;
    logic [3:0]  col_q, col_d;
    logic        full_q, full_d;
    logic [2:0]  lines_q, lines_d;
    logic        top_q, top_d;

    logic [7:0]          coord_x, coord_y;
    logic [COLOUR_W-1:0] colour;
    logic [1:0]          cx, cy;
    logic [7:0]          cell_x, cell_y, ax, ay;
    logic                row_full;

    lut u_lut (
        .block    (blk_q),
        .rotation (rot_q),
        .coord_x  (coord_x),
        .coord_y  (coord_y),
        .colour   (colour)
    );

    board_addr u_board_addr (
        .x    (ax),
        .y    (ay),
        .addr (ram_addr)
    );

    assign cx       = 2'(coord_x >> {k_q, 1'b0});
    assign cy       = 2'(coord_y >> {k_q, 1'b0});
    assign cell_x   = {3'b000, x_q} + {6'b0, cx};
    assign cell_y   = {2'b00, y_q} + {6'b0, cy};
    assign row_full = full_q & (|ram_Q);

    always_comb begin
        ax       = {4'b0, col_q};
        ay       = 8'd0;
        ram_data = '0;
        ram_wren = 1'b0;
        case (state_q)
            WRITE: begin
                ax       = cell_x;
                ay       = cell_y;
                ram_data = colour;
                ram_wren = 1'b1;
            end
            SCAN:      ay = {3'b000, row_q};
            SHIFT_RD:  ay = {3'b000, shf_q} - 8'd1;
            SHIFT_WR: begin
                ay       = {3'b000, shf_q};
                ram_data = ram_Q;
                ram_wren = 1'b1;
            end
            CLEAR_TOP: ram_wren = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        blk_d   = blk_q;
        rot_d   = rot_q;
        k_d     = k_q;
        row_d   = row_q;
        shf_d   = shf_q;
        col_d   = col_q;
        full_d  = full_q;
        lines_d = lines_q;
        top_d   = top_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    x_d     = X_anchor;
                    y_d     = Y_anchor;
                    blk_d   = block;
                    rot_d   = rotation;
                    k_d     = 2'd0;
                    lines_d = 3'd0;
                    top_d   = 1'b0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cell_y < 8'(HIDDEN_ROWS)) top_d = 1'b1;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    row_d   = LAST_ROW;
                    col_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // read data lags the address by one cycle, so column 0 only seeds the accumulator
                full_d = (col_q == 4'd0) ? 1'b1 : row_full;
                col_d  = col_q + 4'd1;
                if (col_q == ACC_COL) begin
                    col_d = 4'd0;
                    if (row_full) begin
                        if (lines_q != 3'd4) lines_d = lines_q + 3'd1;
                        shf_d   = row_q;
                        state_d = (row_q == 5'd0) ? CLEAR_TOP : SHIFT_RD;
                    end else if (row_q == 5'd0) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q - 5'd1;
                    end
                end
            end
            SHIFT_RD: state_d = SHIFT_WR;
            SHIFT_WR: begin
                state_d = SHIFT_RD;
                col_d   = col_q + 4'd1;
                if (col_q == LAST_COL) begin
                    col_d = 4'd0;
                    if (shf_q == 5'd1) state_d = CLEAR_TOP;
                    else shf_d = shf_q - 5'd1;
                end
            end
            CLEAR_TOP: begin
                col_d = col_q + 4'd1;
                if (col_q == LAST_COL) begin
                    col_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            blk_q   <= '0;
            rot_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
            shf_q   <= '0;
            col_q   <= '0;
            full_q  <= 1'b0;
            lines_q <= '0;
            top_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blk_q   <= blk_d;
            rot_q   <= rot_d;
            k_q     <= k_d;
            row_q   <= row_d;
            shf_q   <= shf_d;
            col_q   <= col_d;
            full_q  <= full_d;
            lines_q <= lines_d;
            top_q   <= top_d;
        end
    end

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign complete      = (state_q == DONE);
    assign lines_cleared = lines_q;
    assign top_out       = top_q;
endmodule
